// File: rtl/lvdc_pkg.sv
// Shared LVDC serial-interface types and helpers for the transmitter and the receiver model.
package lvdc_pkg;

    localparam int unsigned LVDC_WORD_W = 26;
    localparam int unsigned LVDC_PAR_W  = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_TERM,
        ST_GAP
    } lvdc_tx_state_t;

    // Odd-parity bit: makes the total count of ones (word + parity) odd.
    // Narrower words are zero-extended by the caller, which leaves the result unchanged.
    function automatic logic lvdc_odd_parity(input logic [LVDC_PAR_W-1:0] word);
        return ~^word;
    endfunction

endpackage

// File: rtl/lvdc_bit_timer.sv
// Bit-slot divider: counts CLK cycles inside a slot while run is high, clears otherwise.
module lvdc_bit_timer #(
    parameter int unsigned BIT_DIV = 4
) (
    input  logic CLK,
    input  logic CSTN,
    input  logic run,
    output logic mid_c,
    output logic tick_c
);

    localparam int unsigned DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;

    logic [DIV_W-1:0] div;

    always_ff @(posedge CLK or negedge CSTN) begin
        if (!CSTN) begin
            div <= '0;
        end else if (!run || tick_c) begin
            div <= '0;
        end else begin
            div <= div + DIV_W'(1);
        end
    end

    // mid_c fires one cycle early so the registered strobe lands on divider == BIT_DIV/2.
    assign mid_c  = run && (div == DIV_W'(BIT_DIV / 2 - 1));
    assign tick_c = run && (div == DIV_W'(BIT_DIV - 1));

endmodule

// File: rtl/lvdc_serial_tx.sv
// LVDC serial-input transmitter: shifts one word out MSB-first on DIN with DATAV/TER strobes.
// Define LVDC_TX_PARITY_EN to append an odd-parity slot after the LSB.
module lvdc_serial_tx
    import lvdc_pkg::*;
#(
    parameter int unsigned WORD_W  = LVDC_WORD_W,
    parameter int unsigned BIT_DIV = 4,
    parameter int unsigned GAP     = 2
) (
    input  logic              CLK,
    input  logic              CSTN,
    input  logic              LOAD,
    input  logic [WORD_W-1:0] WORD,
    output logic              READY,
    output logic              DIN,
    output logic              DATAV,
    output logic              TER
);

`ifdef LVDC_TX_PARITY_EN
    localparam int unsigned PAR_SLOTS = 1;
`else
    localparam int unsigned PAR_SLOTS = 0;
`endif
    localparam int unsigned NSLOT    = WORD_W + PAR_SLOTS;
    localparam int unsigned SLOT_CNT = (NSLOT > GAP) ? NSLOT : GAP;
    localparam int unsigned SLOT_W   = (SLOT_CNT > 1) ? $clog2(SLOT_CNT) : 1;

    lvdc_tx_state_t    state;
    lvdc_tx_state_t    state_nxt;
    logic [NSLOT-1:0]  sh;
    logic [NSLOT-1:0]  load_val;
    logic [SLOT_W-1:0] slot;
    logic              run;
    logic              mid_c;
    logic              tick_c;
    logic              load_c;
    logic              ter_nxt;

`ifdef LVDC_TX_PARITY_EN
    assign load_val = {WORD, lvdc_odd_parity(LVDC_PAR_W'(WORD))};
`else
    assign load_val = WORD;
`endif

    assign run = (state == ST_SHIFT) || (state == ST_GAP);

    lvdc_bit_timer #(
        .BIT_DIV(BIT_DIV)
    ) u_timer (
        .CLK   (CLK),
        .CSTN  (CSTN),
        .run   (run),
        .mid_c (mid_c),
        .tick_c(tick_c)
    );

    always_ff @(posedge CLK or negedge CSTN) begin
        if (!CSTN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The edge that ends the gap is also the first ready edge, so a held LOAD loses no cycle.
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        ter_nxt   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (LOAD && READY) begin
                    state_nxt = ST_SHIFT;
                    load_c    = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (tick_c && (slot == SLOT_W'(NSLOT - 1))) begin
                    state_nxt = ST_TERM;
                    ter_nxt   = 1'b1;
                end
            end
            ST_TERM: begin
                if (GAP != 0) begin
                    state_nxt = ST_GAP;
                end else if (LOAD) begin
                    state_nxt = ST_SHIFT;
                    load_c    = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (tick_c && (slot == SLOT_W'(GAP - 1))) begin
                    if (LOAD) begin
                        state_nxt = ST_SHIFT;
                        load_c    = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Shift register drains to zero, so its MSB is DIN directly and is low outside data slots.
    always_ff @(posedge CLK or negedge CSTN) begin
        if (!CSTN) begin
            sh    <= '0;
            slot  <= '0;
            READY <= 1'b1;
            DATAV <= 1'b0;
            TER   <= 1'b0;
        end else begin
            READY <= (state_nxt == ST_IDLE);
            DATAV <= (state == ST_SHIFT) && mid_c;
            TER   <= ter_nxt;
            if (load_c) begin
                sh <= load_val;
            end else if ((state == ST_SHIFT) && tick_c) begin
                sh <= {sh[NSLOT-2:0], 1'b0};
            end
            if (state_nxt != state) begin
                slot <= '0;
            end else if (tick_c) begin
                slot <= slot + SLOT_W'(1);
            end
        end
    end

    assign DIN = sh[NSLOT-1];

endmodule
